// File: rtl/push_fifo.sv
// push_fifo
//
// Single-clock first-word-fall-through FIFO placed directly after the RS-232
// receiver. Bytes arrive on a push interface and leave on a pop interface
// whose head word is always visible on odata. iafull feeds the receiver's
// almost-full (RTS) input. AFULL_SLACK leaves enough free slots to absorb the
// bytes the remote end still sends after RTS drops.
//
// Parameters
//   DATA_WIDTH   word width
//   ADDR_WIDTH   log2 of depth (DEPTH = 2**ADDR_WIDTH), legal 2..10
//   AFULL_SLACK  free-slot threshold for iafull, legal 1..DEPTH-1
//
// Ports
//   clock     in   rising-edge clock
//   resetn    in   asynchronous active-low reset
//   idata     in   push data
//   iwrite    in   push strobe, one word per cycle
//   ifull     out  no free slot; a push this cycle is dropped
//   iafull    out  occupancy >= DEPTH-AFULL_SLACK
//   odata     out  head word, valid while oempty=0
//   oempty    out  FIFO holds no words
//   oread     in   pop strobe, consumes head at this edge
//   ocount    out  occupancy 0..DEPTH
//   overflow  out  sticky, set by a push while ifull=1
module push_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_SLACK = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  iwrite,
    output logic                  ifull,
    output logic                  iafull,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  oempty,
    input  logic                  oread,
    output logic [ADDR_WIDTH:0]   ocount,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int AFULL_LEVEL = DEPTH - AFULL_SLACK;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] C_AFULL = AFULL_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] C_ZERO  = '0;

    // Storage array is deliberately not reset; odata is don't-care while empty.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_overflow;

    logic                  w_do_write;
    logic                  w_do_read;
    logic [ADDR_WIDTH:0]   w_count_next;

    // Both strobes are gated by the registered flags, so a push while full is
    // dropped even when a pop frees a slot at the same edge.
    assign w_do_write = iwrite && !r_full;
    assign w_do_read  = oread  && !r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_do_write, w_do_read})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_do_write) begin
            r_mem[r_wptr] <= idata;
        end
    end

    // Flags are loaded from count_next so they change at the same edge as the
    // operation that causes them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_write) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_read) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (iwrite && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == C_DEPTH);
            r_empty <= (w_count_next == C_ZERO);
            r_afull <= (w_count_next >= C_AFULL);
        end
    end

    assign odata    = r_mem[r_rptr];
    assign ifull    = r_full;
    assign oempty   = r_empty;
    assign iafull   = r_afull;
    assign ocount   = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_push_fifo.sv
module tb_push_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int SLACK = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b1;
    logic [DW-1:0] idata = '0;
    logic          iwrite = 1'b0;
    logic          oread = 1'b0;
    logic          ifull, iafull, oempty, overflow;
    logic [DW-1:0] odata;
    logic [AW:0]   ocount;

    push_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_SLACK(SLACK)) dut (
        .clock(clock), .resetn(resetn), .idata(idata), .iwrite(iwrite),
        .ifull(ifull), .iafull(iafull), .odata(odata), .oempty(oempty),
        .oread(oread), .ocount(ocount), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of stored words plus the sticky overflow bit.
    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;

    typedef struct {
        bit            w;
        bit            r;
        logic [DW-1:0] d;
        int            cnt;
        bit            emp;
        bit            full;
        bit            af;
        bit            ovf;
        bit            chk_od;
        logic [DW-1:0] od;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("ocount", 32'(ocount), q.size());
        chk("oempty", 32'(oempty), 32'(q.size() == 0));
        chk("ifull", 32'(ifull), 32'(q.size() == DEPTH));
        chk("iafull", 32'(iafull), 32'(q.size() >= DEPTH - SLACK));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() > 0) chk("odata", 32'(odata), 32'(q[0]));
    endtask

    // One clock cycle: drive, update model from pre-edge state, check after edge.
    task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d);
        int n;
        bit dw, dr;
        iwrite = w; oread = r; idata = d;
        n  = q.size();
        dw = w && (n < DEPTH);
        dr = r && (n > 0);
        if (w && n == DEPTH) m_ovf = 1'b1;
        @(posedge clock);
        if (dr) void'(q.pop_front());
        if (dw) q.push_back(d);
        #1;
        check_model();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, releases it.
    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        chk("rst_ocount", 32'(ocount), 0);
        chk("rst_oempty", 32'(oempty), 1);
        chk("rst_ifull", 32'(ifull), 0);
        chk("rst_iafull", 32'(iafull), 0);
        chk("rst_overflow", 32'(overflow), 0);
        q.delete();
        m_ovf = 1'b0;
        iwrite = 1'b0; oread = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Pop on empty is ignored, then a push, then simultaneous push/pop at
        // low occupancy.
        tbl[0] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 8'h7E, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7E};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
        tbl[6] = '{1'b1, 1'b1, 8'h34, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h34};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        do_reset();

        foreach (tbl[i]) begin
            iwrite = tbl[i].w; oread = tbl[i].r; idata = tbl[i].d;
            @(posedge clock);
            #1;
            chk("tbl_ocount", 32'(ocount), tbl[i].cnt);
            chk("tbl_oempty", 32'(oempty), 32'(tbl[i].emp));
            chk("tbl_ifull", 32'(ifull), 32'(tbl[i].full));
            chk("tbl_iafull", 32'(iafull), 32'(tbl[i].af));
            chk("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
            if (tbl[i].chk_od) chk("tbl_odata", 32'(odata), 32'(tbl[i].od));
        end

        // Fill 0x01..0x10.
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk("fill_iafull", 32'(iafull), 32'(i >= 12));
            chk("fill_ifull", 32'(ifull), 32'(i == 16));
        end
        chk("fill_ocount", 32'(ocount), 16);

        // Push while full, then drain.
        cyc(1'b1, 1'b0, 8'hAA);
        chk("ovf_set", 32'(overflow), 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(odata), i + 1);
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_iafull", 32'(iafull), 32'((15 - i) >= 12));
            chk("drain_ovf", 32'(overflow), 1);
        end
        chk("drain_empty", 32'(oempty), 1);

        // Streaming: push and pop every cycle, pointers wrap twice.
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, 8'(8'h40 + i));
            chk("stream_ocount", 32'(ocount), 1);
            chk("stream_head", 32'(odata), 32'(8'h40 + i));
        end
        cyc(1'b0, 1'b1, 8'h00);

        // Push and pop together while full.
        do_reset();
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b1, 8'h55);
        chk("fullrw_ocount", 32'(ocount), 15);
        chk("fullrw_ifull", 32'(ifull), 0);
        chk("fullrw_ovf", 32'(overflow), 1);
        chk("fullrw_head", 32'(odata), 2);
        for (int i = 0; i < 15; i++) begin
            chk("fullrw_no55", 32'(odata), i + 2);
            cyc(1'b0, 1'b1, 8'h00);
        end

        // Reset with 9 words stored.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        chk("mid_ocount", 32'(ocount), 9);
        do_reset();
        cyc(1'b1, 1'b0, 8'h33);
        chk("post_rst_head", 32'(odata), 32'h33);
        cyc(1'b0, 1'b1, 8'h00);
        chk("post_rst_empty", 32'(oempty), 1);

        // Randomized traffic, write-biased then read-biased.
        for (int i = 0; i < 400; i++) begin
            bit w, r;
            w = (i < 200) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 35);
            r = (i < 200) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 70);
            cyc(w, r, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/push_fifo.md
# push_fifo

Synchronous single-clock FIFO that sits directly downstream of the RS-232 receiver. It accepts bytes on a push interface and presents them on a first-word-fall-through pop interface. Its `iafull` output drives the receiver's almost-full input, which is the RTS flow control. The slack parameter absorbs the bytes the remote sender transmits after RTS deasserts.

## Interface
- `DATA_WIDTH`, 8, width of each word.
- `ADDR_WIDTH`, 4, depth is DEPTH = 2**ADDR_WIDTH words; legal range 2..10.
- `AFULL_SLACK`, 4, free-slot threshold for `iafull`; legal range 1..DEPTH-1.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `idata`  in  DATA_WIDTH  push data.
- `iwrite`  in  1  push strobe; one word per cycle while high.
- `ifull`  out  1  no free slot; a push in this cycle is dropped.
- `iafull`  out  1  high while occupancy >= DEPTH-AFULL_SLACK.
- `odata`  out  DATA_WIDTH  head word; valid only while `oempty`=0.
- `oempty`  out  1  FIFO holds no words.
- `oread`  in  1  pop strobe; consumes the head word at this edge.
- `ocount`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a push arrives while `ifull`=1.

## Operation
- Storage is a DEPTH x DATA_WIDTH register array with write pointer `wptr` and read pointer `rptr`, each ADDR_WIDTH bits.
  - Pointers wrap modulo DEPTH naturally.
  - The array is not reset.
- Occupancy counter `count`, ADDR_WIDTH+1 bits, unsigned.
- do_write = `iwrite` && !`ifull`. On do_write: mem[wptr] <= `idata`, wptr <= wptr+1.
- do_read = `oread` && !`oempty`. On do_read: rptr <= rptr+1.
- count_next:
  - count+1 if only do_write;
  - count-1 if only do_read;
  - count if both or neither.
- `ifull`, `oempty`, `iafull` are registers loaded from count_next:
  - `ifull` = (count_next == DEPTH)
  - `oempty` = (count_next == 0)
  - `iafull` = (count_next >= DEPTH-AFULL_SLACK)
- `ocount` is the `count` register.
- `odata` = mem[rptr], a combinational read of the array.
- Pushing while full is dropped. The array and pointers are unchanged, and `overflow` <= 1 until the next reset.
- Popping while empty is ignored silently. There is no underflow flag.
- Simultaneous push and pop:
  - When full: the pop happens, the push is dropped (it is gated by the registered `ifull`=1), `overflow` is set, and count becomes DEPTH-1.
  - When empty: the push happens, the pop is ignored, and count becomes 1.
  - Otherwise: both happen and count is unchanged.
- Reset (asynchronous, any time, including mid-burst) forces these values:
  - wptr=0, rptr=0, count=0;
  - `oempty`=1, `ifull`=0, `iafull`=0, `overflow`=0, `ocount`=0.
  - `odata` is don't-care after reset.
  - Release takes effect at the first clock edge after `resetn` rises.

## Timing
- Push-to-pop latency is 1 cycle. For a word pushed at edge N into an empty FIFO:
  - `oempty` falls after edge N;
  - `odata` shows the word in cycle N+1;
  - a pop asserted in cycle N+1 consumes it at edge N+1.
- Sustained throughput is one push and one pop per cycle with no bubbles.
- All flags update at the same edge as the operation that causes them; there are no stale flag cycles.
- `iafull` reaches the receiver's RTS 1 cycle after the triggering push. AFULL_SLACK must cover this cycle plus the remote sender's reaction time in bytes.
- `odata` changes only at edges where do_read occurs, or at the first push into an empty FIFO.

## Test plan
- Reset, then push 0x01..0x10 on consecutive cycles with `oread`=0 (DEPTH=16, AFULL_SLACK=4):
  - `iafull` rises after the 12th push edge;
  - `ifull` rises after the 16th;
  - `ocount`=16;
  - `oempty`=0 after the first edge.
- From full, push 0xAA; then pop 16 words:
  - `overflow`=1 and stays 1;
  - pops yield 0x01..0x10 in order;
  - `oempty`=1 after the 16th pop;
  - `iafull` falls when `ocount` drops to 11.
- From empty, hold `iwrite`=`oread`=1 for 40 cycles with incrementing data:
  - the first cycle gives a push only (count 1);
  - after that `ocount` stays 1;
  - the popped sequence equals the pushed sequence delayed by 1;
  - pointers wrap twice with no corruption.
- At full, assert push 0x55 and pop in the same cycle:
  - head 0x01 is consumed;
  - 0x55 is not stored;
  - `ocount`=15, `ifull`=0, `overflow`=1.
- Pop while empty for 3 cycles, then push 0x7E:
  - `ocount` stays 0 and `overflow` stays 0;
  - `odata`=0x7E, `oempty`=0 the next cycle.
- Assert `resetn`=0 mid-way with `ocount`=9:
  - all flags go to reset values immediately (asynchronously);
  - after release, a push of 0x33 followed by a pop returns 0x33.
